// File: rtl/matrix_rom_streamer_if.sv
// rtl/matrix_rom_streamer_if.sv - packed-word output stream of the coefficient table
interface matrix_rom_streamer_if #(
    parameter int DATA_W = 14
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_rom_streamer.sv
// rtl/matrix_rom_streamer.sv - loadable ROWS x COLS coefficient table streamed as packed words
module matrix_rom_streamer #(
    parameter int ELEM_W = 7,
    parameter int ROWS   = 8,
    parameter int COLS   = 4,
    parameter int PACK   = 2,
    parameter int AW     = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [ELEM_W-1:0] load_data,
    input  logic              start,
    input  logic              col_major,
    output logic              busy,
    output logic              done,
    matrix_rom_streamer_if.master strm
);
    localparam int NUM = ROWS * COLS;
    localparam int N   = NUM / PACK;
    localparam int RB  = ROWS / PACK;
    localparam int CB  = COLS / PACK;
    localparam int CW  = $clog2(N) + 1;
    localparam int DW  = PACK * ELEM_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [ELEM_W-1:0] mem [NUM];
    logic [CW-1:0]     cnt;
    logic              mode;

    // Gather the PACK elements of word k; lane 0 lands in the low bits.
    function automatic logic [DW-1:0] word_at(input logic [CW-1:0] k, input logic cm);
        logic [DW-1:0] w;
        int            kk;
        int            idx;
        w  = '0;
        kk = int'(k);
        for (int i = 0; i < PACK; i++) begin
            if (cm)
                idx = ((kk % RB) * PACK + i) * COLS + kk / RB;
            else
                idx = (kk / CB) * COLS + (kk % CB) * PACK + i;
            w[i*ELEM_W +: ELEM_W] = mem[AW'(idx)];
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
            strm.out_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cnt            <= '0;
            mode           <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[AW'(r*COLS + c)] <= (c == 0) ? ELEM_W'(r + 1) : ELEM_W'(1);
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en && (int'(load_addr) < NUM))
                        mem[load_addr] <= load_data;
                    if (start) begin
                        mode           <= col_major;
                        strm.out_data  <= word_at('0, col_major);
                        strm.out_valid <= 1'b1;
                        strm.out_last  <= (N == 1);
                        cnt            <= CW'(1);
                        busy           <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (strm.out_valid && strm.out_ready) begin
                        if (strm.out_last) begin
                            // out_data deliberately keeps the final word
                            strm.out_valid <= 1'b0;
                            strm.out_last  <= 1'b0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            strm.out_data <= word_at(cnt, mode);
                            strm.out_last <= (cnt == CW'(N - 1));
                            cnt           <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_rom_streamer.sv
// tb/tb_matrix_rom_streamer.sv - scoreboard bench for matrix_rom_streamer
module tb_matrix_rom_streamer;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_en = 1'b0;
    logic [4:0] load_addr = '0;
    logic [6:0] load_data = '0;
    logic       start = 1'b0;
    logic       col_major = 1'b0;
    logic       busy;
    logic       done;

    matrix_rom_streamer_if #(.DATA_W(14)) strm();

    matrix_rom_streamer #(.ELEM_W(7), .ROWS(8), .COLS(4), .PACK(2)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .col_major(col_major),
        .busy(busy), .done(done), .strm(strm)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [6:0]  model [32];
    logic [13:0] exp_q [$];
    logic [13:0] got_q [$];
    logic        last_q [$];
    int          cyc_q [$];
    int          hs;
    int          stall_bad;

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++)
                model[r*4 + c] = (c == 0) ? 7'(r + 1) : 7'd1;
    endtask

    function automatic logic [13:0] model_word(int k, bit cm);
        int a0, a1;
        if (cm) begin
            a0 = ((k % 4) * 2) * 4 + k / 4;
            a1 = a0 + 4;
        end else begin
            a0 = (k / 2) * 4 + (k % 2) * 2;
            a1 = a0 + 1;
        end
        return {model[a1], model[a0]};
    endfunction

    task automatic do_load(input int addr, input int val);
        load_en = 1'b1; load_addr = 5'(addr); load_data = 7'(val);
        @(negedge clk);
        load_en = 1'b0;
        model[addr] = 7'(val);
    endtask

    task automatic do_start(input bit cm);
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(model_word(k, cm));
        col_major = cm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumer: records handshaken words; optional stall, mid-run start pulse, abort reset.
    task automatic collect(input int stall_word, input int stall_n, input int start_cyc, input int rst_after);
        int cyc;
        int left;
        logic [13:0] held;
        got_q.delete(); last_q.delete(); cyc_q.delete();
        hs = 0; stall_bad = 0; cyc = 0; left = stall_n; held = '0;
        while (1) begin
            if (cyc > 200) begin
                total++; bad++;
                $display("FAIL collect_timeout: handshakes %0d within 200 cycles, want %0d", hs, N);
                break;
            end
            start = (cyc == start_cyc);
            if (hs == stall_word && left > 0) begin
                if (left < stall_n && (!strm.out_valid || strm.out_data !== held)) stall_bad++;
                held = strm.out_data; strm.out_ready = 1'b0; left--;
            end else begin
                if (stall_n > 0 && hs == stall_word && strm.out_data !== held) stall_bad++;
                strm.out_ready = 1'b1;
            end
            if (strm.out_valid && strm.out_ready) begin
                got_q.push_back(strm.out_data);
                last_q.push_back(strm.out_last);
                cyc_q.push_back(cyc);
                hs++;
                if (strm.out_last) begin
                    @(negedge clk); load_en = 1'b0;
                    break;
                end
                if (hs == rst_after) begin
                    @(negedge clk); rst = 1'b0;
                    break;
                end
            end
            @(negedge clk); load_en = 1'b0;
            cyc++;
        end
        start = 1'b0;
        strm.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        total++; if (strm.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", strm.out_valid); end
        total++; if (strm.out_data !== 14'd0) begin bad++; $display("FAIL reset_data: got %0d want 0", strm.out_data); end
        total++; if ({busy, done, strm.out_last} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, strm.out_last}); end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_col_major();
        int want [4] = '{257, 515, 773, 1031};
        do_start(1'b1);
        total++; if (strm.out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL col_first_valid: got valid=%b busy=%b want 1 1", strm.out_valid, busy); end
        collect(-1, 0, -1, -1);
        total++; if (hs !== N) begin bad++; $display("FAIL col_handshakes: got %0d want %0d", hs, N); end
        total++; if (done !== 1'b1 || strm.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL col_done: got done=%b valid=%b busy=%b want 1 0 0", done, strm.out_valid, busy); end
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL col_word%0d: got %0d want %0d", i, got_q[i], e); end
            total++; if (last_q[i] !== (i == N-1)) begin bad++; $display("FAIL col_last%0d: got %b want %b", i, last_q[i], i == N-1); end
            total++; if (got_q[i] !== ((i < 4) ? 14'(want[i]) : 14'd129)) begin bad++; $display("FAIL col_const%0d: got %0d", i, got_q[i]); end
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL col_done_width: got %b want 0", done); end
    endtask

    task automatic test_row_major();
        rst = 1'b0; @(negedge clk); rst = 1'b1; model_reset();
        do_start(1'b0);
        collect(-1, 0, -1, -1);
        total++; if (hs !== N) begin bad++; $display("FAIL row_handshakes: got %0d want %0d", hs, N); end
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL row_word%0d: got %0d want %0d", i, got_q[i], e); end
        end
        total++; if ({got_q[0], got_q[1], got_q[2]} !== {14'd129, 14'd129, 14'd130}) begin bad++; $display("FAIL row_const012: got %0d %0d %0d want 129 129 130", got_q[0], got_q[1], got_q[2]); end
        total++; if ({got_q[14], got_q[15]} !== {14'd136, 14'd129}) begin bad++; $display("FAIL row_const14_15: got %0d %0d want 136 129", got_q[14], got_q[15]); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_start(1'b1);
        collect(2, 3, -1, -1);
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", stall_bad); end
        total++; if (hs !== N) begin bad++; $display("FAIL bp_handshakes: got %0d want %0d", hs, N); end
        total++; if (got_q[2] !== 14'd773 || got_q[3] !== 14'd1031) begin bad++; $display("FAIL bp_words: got %0d %0d want 773 1031", got_q[2], got_q[3]); end
        total++; if (cyc_q[2] - cyc_q[1] !== 4 || cyc_q[3] - cyc_q[2] !== 1) begin bad++; $display("FAIL bp_timing: got gaps %0d %0d want 4 1", cyc_q[2] - cyc_q[1], cyc_q[3] - cyc_q[2]); end
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL bp_word%0d: got %0d want %0d", i, got_q[i], e); end
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        do_load(9, 85);
        do_start(1'b1);
        load_en = 1'b1; load_addr = 5'd0; load_data = 7'd0;
        collect(-1, 0, -1, -1);
        total++; if (got_q[5] !== 14'd213) begin bad++; $display("FAIL load_word5: got %0d want 213", got_q[5]); end
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL load_word%0d: got %0d want %0d", i, got_q[i], e); end
        end
        @(negedge clk);
        do_start(1'b1);
        collect(-1, 0, -1, -1);
        total++; if (got_q[0] !== 14'd257 || got_q[0] !== exp_q[0]) begin bad++; $display("FAIL load_in_run_word0: got %0d want 257", got_q[0]); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int extra_done;
        do_load(4, 50);
        do_start(1'b1);
        collect(-1, 0, -1, 5);
        total++; if (hs !== 5) begin bad++; $display("FAIL abort_handshakes: got %0d want 5", hs); end
        @(negedge clk);
        total++; if ({strm.out_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL abort_state: got valid/busy/done=%b want 000", {strm.out_valid, busy, done}); end
        rst = 1'b1;
        model_reset();
        extra_done = 0;
        repeat (3) begin @(negedge clk); if (done !== 1'b0) extra_done++; end
        total++; if (extra_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d done cycles want 0", extra_done); end
        do_start(1'b1);
        collect(-1, 0, -1, -1);
        total++; if (hs !== N) begin bad++; $display("FAIL abort_rerun_handshakes: got %0d want %0d", hs, N); end
        total++; if (got_q[1] !== 14'd515) begin bad++; $display("FAIL abort_revert: got %0d want 515", got_q[1]); end
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL abort_word%0d: got %0d want %0d", i, got_q[i], e); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_start(1'b1);
        col_major = 1'b0;
        collect(-1, 0, 5, -1);
        total++; if (hs !== N) begin bad++; $display("FAIL b2b_first_handshakes: got %0d want %0d", hs, N); end
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL b2b_first_word%0d: got %0d want %0d", i, got_q[i], e); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
        do_start(1'b0);
        total++; if (strm.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_restart_valid: got %b want 1", strm.out_valid); end
        collect(-1, 0, -1, -1);
        total++; if (hs !== N) begin bad++; $display("FAIL b2b_second_handshakes: got %0d want %0d", hs, N); end
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL b2b_second_word%0d: got %0d want %0d", i, got_q[i], e); end
        end
        @(negedge clk);
    endtask

    initial begin
        strm.out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_col_major();
        test_row_major();
        test_backpressure();
        test_load();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_rom_streamer.md
Name: matrix_rom_streamer

Overview:
Coefficient table for the matrix datapath, parametrised in element width, matrix shape and packing factor.
- Holds a ROWS x COLS matrix of ELEM_W-bit elements.
- On a start pulse, streams the whole matrix as packed words of PACK adjacent elements, in column-major or row-major order.
- Uses a valid/ready handshake with backpressure.
- Contents reload to a default pattern on reset and can be overwritten through a load port while idle.
- Sits between the controller and the multiply-accumulate array, replacing fixed-address combinational lookup.

Parameters:
ELEM_W, 7, element width in bits
ROWS, 8, matrix rows; must be a multiple of PACK
COLS, 4, matrix columns; must be a multiple of PACK
PACK, 2, elements per output word; out_data is PACK*ELEM_W bits
AW, clog2(ROWS*COLS), load address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
load_en  in  1  write one element (honoured only in IDLE)
load_addr  in  AW  element index r*COLS+c; indices >= ROWS*COLS are ignored
load_data  in  ELEM_W  element value
start  in  1  begin streaming (honoured only in IDLE)
col_major  in  1  order, sampled at accepted start: 1 = column-major, 0 = row-major
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer accepts word
out_data  out  PACK*ELEM_W  packed word; the lower-indexed element is in bits [ELEM_W-1:0]
out_last  out  1  qualifies the final word of the matrix
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Clock and reset
  - One clock: clk. Reset rst is synchronous and active-low.
  - On reset: state = IDLE; out_valid, out_data, out_last, busy and done = 0; word counter = 0.
  - Reset mid-stream aborts immediately with no done pulse.
- Default table contents
  - Reset loads every element: elem(r,c) = r+1 when c = 0, else 1, truncated to ELEM_W.
- Load port
  - In IDLE, load_en writes load_data to element load_addr at the clock edge.
  - Load is ignored in RUN.
- States
  - IDLE: start=1 latches col_major, clears the counter and goes to RUN. busy rises on the next cycle.
  - RUN: streams words. The final handshake returns to IDLE, with done=1 for exactly one cycle in that next cycle.
  - A start asserted in that done cycle is accepted, giving back-to-back streams.
  - start during RUN is ignored.
- Word count and ordering
  - N = ROWS*COLS/PACK words per stream, k = 0..N-1.
  - Column-major: word k = elements rows p..p+PACK-1 of column c, where c = k / (ROWS/PACK) and p = (k mod (ROWS/PACK))*PACK.
  - Row-major: word k = elements columns q..q+PACK-1 of row r, where r = k / (COLS/PACK) and q = (k mod (COLS/PACK))*PACK.
- Timing and handshake
  - out_data and out_valid are registered. Word 0 is valid the cycle after the accepted start.
  - On each handshake (out_valid & out_ready), the next word appears the following cycle. Throughput is 1 word/cycle.
  - With out_valid=1 and out_ready=0, out_data, out_last and out_valid hold stable.
  - out_valid never drops before its handshake.
  - out_last = 1 only with word N-1.
  - After the final handshake, out_valid = 0 and out_data keeps its last value.

Test Plan:
1. Reset, then start with col_major=1 and out_ready=1 held. Required:
   - Words 0..3 = 257, 515, 773, 1031.
   - Words 4..15 = 129.
   - out_last on word 15, done pulse one cycle after it, busy low afterwards.
2. Reset, then start with col_major=0. Required:
   - Word 0 = 129, word 1 = 129, word 2 = 130 (elem(1,0)=2 low, elem(1,1)=1 high).
   - Word 14 = 136, word 15 = 129.
3. Column-major stream with out_ready low for 3 cycles while word 2 is presented. Required:
   - out_data holds 773 and out_valid stays 1 throughout.
   - Word 3 = 1031 appears one cycle after ready rises.
   - Total 16 handshakes.
4. Load addr 9 = 85 in IDLE, then column-major stream. Required:
   - Word 5 = 213 (low 85, high 1).
   - A load to addr 0 = 0 issued during RUN does not change the next stream's word 0 = 257.
5. Assert rst=0 for one cycle after the 5th handshake. Required:
   - Next cycle out_valid = busy = done = 0, with no done pulse.
   - A load made before the reset is reverted; a new column-major stream reproduces scenario 1 exactly.
6. Assert start on the done cycle, and start during RUN. Required:
   - Start on the done cycle: a second stream begins with word 0 valid on the next cycle.
   - Start during RUN: ignored, counter unaffected, 16 words per stream.
